// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one I2C byte master.
// Each transaction is latched in IDLE, handed to the master, and ends in a response or a timeout.
module i2c_req_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned TIMEOUT_CYC = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [NREQ-1:0]   req_op,
  input  logic [8*NREQ-1:0] req_din,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_done,
  output logic [7:0]        rsp_dout,
  output logic              rsp_ack_err,
  output logic              rsp_timeout,
  output logic              arb_busy,
  output logic              m_newd,
  output logic [6:0]        m_addr,
  output logic              m_op,
  output logic [7:0]        m_din,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic              m_ack_err,
  input  logic [7:0]        m_dout
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
  localparam logic [1:0] RESP      = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]  win_q, win_d;
  logic [IDW-1:0]  last_id_q, last_id_d;
  logic [6:0]      addr_q, addr_d;
  logic            op_q, op_d;
  logic [7:0]      din_q, din_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      dout_q, dout_d;
  logic            ack_q, ack_d;
  logic            to_q, to_d;

  logic [IDW-1:0]  pick;
  logic            pick_vld;
  logic [6:0]      sel_addr;
  logic            sel_op;
  logic [7:0]      sel_din;

  // Two passes: indices above last_id first, then wrap around to 0..last_id.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!pick_vld && req[j] && (IDW'(j) > last_id_q)) begin
        pick     = IDW'(j);
        pick_vld = 1'b1;
      end
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (!pick_vld && req[j] && (IDW'(j) <= last_id_q)) begin
        pick     = IDW'(j);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_op   = 1'b0;
    sel_din  = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (pick == IDW'(j)) begin
        sel_addr = req_addr[7*j +: 7];
        sel_op   = req_op[j];
        sel_din  = req_din[8*j +: 8];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    win_d     = win_q;
    last_id_d = last_id_q;
    addr_d    = addr_q;
    op_d      = op_q;
    din_d     = din_q;
    cnt_d     = cnt_q;
    dout_d    = dout_q;
    ack_d     = ack_q;
    to_d      = to_q;
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_vld && !m_busy) begin
          win_d   = pick;
          gnt_d   = NREQ'(1) << pick;
          addr_d  = sel_addr;
          op_d    = sel_op;
          din_d   = sel_din;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        // m_done is checked first so it wins over a coincident timeout.
        if (m_done) begin
          dout_d  = m_dout;
          ack_d   = m_ack_err;
          to_d    = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          ack_d   = 1'b1;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        last_id_d = win_q;
        gnt_d     = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      win_q     <= '0;
      last_id_q <= IDW'(NREQ - 1);
      addr_q    <= '0;
      op_q      <= 1'b0;
      din_q     <= '0;
      cnt_q     <= '0;
      dout_q    <= '0;
      ack_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      win_q     <= win_d;
      last_id_q <= last_id_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      din_q     <= din_d;
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      ack_q     <= ack_d;
      to_q      <= to_d;
    end
  end

  assign gnt         = gnt_q;
  assign rsp_done    = (state_q == RESP) ? gnt_q : '0;
  assign rsp_dout    = dout_q;
  assign rsp_ack_err = ack_q;
  assign rsp_timeout = to_q;
  assign arb_busy    = (state_q != IDLE);
  assign m_newd      = (state_q == ISSUE);
  assign m_addr      = addr_q;
  assign m_op        = op_q;
  assign m_din       = din_q;

endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, the number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 20000, the maximum clk cycles allowed for one transaction.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port req, input, NREQ bits: level request per requester.
REQ-006 SHALL have port req_addr, input, 7*NREQ bits: 7-bit slave address per requester; requester i uses bits [7i+6:7i].
REQ-007 SHALL have port req_op, input, NREQ bits: operation per requester (1 = read).
REQ-008 SHALL have port req_din, input, 8*NREQ bits: write byte per requester; requester i uses bits [8i+7:8i].
REQ-009 SHALL have port gnt, output, NREQ bits: one-hot, high for the requester being served.
REQ-010 SHALL have port rsp_done, output, NREQ bits: one-cycle completion pulse to the served requester.
REQ-011 SHALL have port rsp_dout, output, 8 bits: read byte from the last transaction.
REQ-012 SHALL have port rsp_ack_err, output, 1 bit: the last transaction was NACKed or timed out.
REQ-013 SHALL have port rsp_timeout, output, 1 bit: the last transaction timed out.
REQ-014 SHALL have port arb_busy, output, 1 bit: the arbiter is not in IDLE.
REQ-015 SHALL have master-side outputs m_newd (1), m_addr (7), m_op (1) and m_din (8), which drive the I2C master's newd, addr, op and din inputs.
REQ-016 SHALL have master-side inputs m_busy (1), m_done (1), m_ack_err (1) and m_dout (8), taken from the I2C master's busy, done, ack_err and dout outputs.

Function
REQ-017 SHALL implement the states IDLE, ISSUE, WAIT_DONE and RESP.
REQ-018 In IDLE, when req is nonzero and m_busy = 0, SHALL:
- select a winner by round-robin, searching from index last_id+1 upward with wrap-around;
- latch that requester's addr, op and din into internal registers;
- set gnt to the winner's one-hot code;
- go to ISSUE.
REQ-019 In IDLE with req = 0 or m_busy = 1, SHALL stay in IDLE with gnt = 0.
REQ-020 In ISSUE, SHALL assert m_newd high for exactly one cycle, with m_addr, m_op and m_din driven from the latched registers, then go to WAIT_DONE.
REQ-021 m_addr, m_op and m_din SHALL stay stable from ISSUE until leaving WAIT_DONE.
REQ-022 In WAIT_DONE, SHALL increment a timeout counter each cycle, starting from 0 on entry.
REQ-023 In WAIT_DONE, on m_done = 1, SHALL:
- capture m_dout into rsp_dout;
- capture m_ack_err into rsp_ack_err;
- clear rsp_timeout;
- go to RESP.
REQ-024 In WAIT_DONE, if the counter reaches TIMEOUT_CYC-1 without m_done, SHALL set rsp_timeout = 1 and rsp_ack_err = 1, leave rsp_dout unchanged, and go to RESP.
REQ-025 If m_done and the timeout occur in the same cycle, m_done SHALL win.
REQ-026 In RESP, SHALL pulse rsp_done[winner] for one cycle, update last_id to the winner, clear gnt, and go to IDLE.
REQ-027 rsp_dout, rsp_ack_err and rsp_timeout SHALL hold their values until the next RESP.
REQ-028 m_done pulses outside WAIT_DONE SHALL be ignored.
REQ-029 Changes on req or the request buses after the IDLE latch SHALL NOT affect the current transaction.
REQ-030 A requester dropping req mid-transaction SHALL NOT abort it; the transaction completes and rsp_done still pulses.
REQ-031 A requester still holding req in the cycle after its rsp_done SHALL be treated as a new request, served after any other pending requesters.
REQ-032 After a timeout, SHALL NOT issue again until m_busy = 0, per REQ-018.
REQ-033 Transaction latency, counted from IDLE winner selection to rsp_done, SHALL be 3 cycles plus the master's duration.

Reset
REQ-034 While rst = 0, all outputs SHALL be 0, the state SHALL be IDLE, the timeout counter SHALL be 0, and last_id SHALL be NREQ-1, so that requester 0 has first priority.
REQ-035 Reset asserted mid-transaction SHALL immediately drop m_newd, gnt and rsp_done, with no completion pulse.
REQ-036 After rst deasserts, SHALL resume arbitration from IDLE on the next rising clk edge.

Verification
REQ-037 Single request: req = 4'b0100, addr 0x50, op 0, din 0xA5; master model completes with ack_err 0 -> exactly one m_newd pulse with m_addr 0x50 and m_din 0xA5, gnt = 4'b0100 until RESP, then rsp_done = 4'b0100 for one cycle with rsp_ack_err = 0.
REQ-038 Read: requester 1 with op 1; master returns m_dout 0x3C -> rsp_dout = 0x3C and rsp_done[1] pulses.
REQ-039 Fairness: req = 4'b1111 held high throughout -> grant order 0, 1, 2, 3, 0, with each requester served once per round.
REQ-040 Timeout: TIMEOUT_CYC = 50 and the master never asserts m_done -> RESP reached 50 cycles after entering WAIT_DONE, with rsp_timeout = 1 and rsp_ack_err = 1; the next issue waits for m_busy = 0.
REQ-041 NACK plus collision: m_ack_err = 1 with m_done, and an m_done in the same cycle as the timeout -> rsp_ack_err = 1 and rsp_timeout = 0.
REQ-042 Reset mid-WAIT_DONE -> all outputs 0 immediately, and the next grant goes to requester 0.
